vga_mono_dither: RTL and testbench

- Registered video output stage between the system video source (6-bit-per-channel RGB plus syncs) and the 3-bit-per-channel VGA DAC pins.
- Replaces the combinational colour/monochrome truncation path with a pipelined one, supporting colour, green, amber and white modes.
- Computes luma by shift-add instead of table lookup.
- Applies optional 4x4 ordered (Bayer) dithering when reducing 6 bits to 3.
- Delays hsync/vsync so they stay aligned with the pixel data.

---
 rtl/video_pkg.sv | 51 +++++
 rtl/vga_mono_dither_if.sv | 28 ++
 rtl/vga_luma_weight.sv | 32 +++
 rtl/vga_mono_dither.sv | 149 ++++++++++++++
 tb/tb_vga_mono_dither.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared video constants: mode encodings, luma weights, Bayer table.
// Also the pixel bundle passed between pipeline stages.
package video_pkg;

   localparam logic [1:0] MODE_COLOR = 2'b00;
   localparam logic [1:0] MODE_GREEN = 2'b01;
   localparam logic [1:0] MODE_AMBER = 2'b10;
   localparam logic [1:0] MODE_WHITE = 2'b11;

   localparam logic [7:0] LUMA_WR = 8'd54;
   localparam logic [7:0] LUMA_WG = 8'd183;
   localparam logic [7:0] LUMA_WB = 8'd19;

   localparam logic [3:0] BAYER [16] = '{
      4'd0,  4'd8,  4'd2,  4'd10,
      4'd12, 4'd4,  4'd14, 4'd6,
      4'd3,  4'd11, 4'd1,  4'd9,
      4'd15, 4'd7,  4'd13, 4'd5
   };

   typedef struct packed {
      logic [5:0] r;
      logic [5:0] g;
      logic [5:0] b;
      logic       hs;
      logic       vs;
   } pix_t;

   // Constant weight, so this collapses to a plain shift-add tree.
   function automatic logic [13:0] mul_sa(
      input logic [5:0] v,
      input logic [7:0] w
   );
      logic [13:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
         if (w[i]) acc = acc + (14'(v) << i);
      end
      return acc;
   endfunction

   function automatic logic [2:0] bayer_thr(
      input logic [1:0] y,
      input logic [1:0] x
   );
      logic [3:0] m;
      m = BAYER[{y, x}];
      return m[3:1];
   endfunction

endpackage

// File: rtl/vga_mono_dither_if.sv
// Video source / DAC pin bundle for the VGA output stage.
// slave = output stage, master = video source and pin observer.
interface vga_mono_dither_if;
   logic [5:0] r_in;
   logic [5:0] g_in;
   logic [5:0] b_in;
   logic       hsync_in;
   logic       vsync_in;
   logic [1:0] mode;
   logic       dither_en;
   logic [2:0] VGA_R;
   logic [2:0] VGA_G;
   logic [2:0] VGA_B;
   logic       VGA_HSYNC;
   logic       VGA_VSYNC;

   modport slave (
      input  r_in, g_in, b_in, hsync_in, vsync_in,
      input  mode, dither_en,
      output VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
   );

   modport master (
      output r_in, g_in, b_in, hsync_in, vsync_in,
      output mode, dither_en,
      input  VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
   );
endinterface

// File: rtl/vga_luma_weight.sv
// Registered luma = (54r + 183g + 19b) >> 8 via shift-add.
// Weights sum to 256, so the 14-bit sum never overflows 6 bits.
module vga_luma_weight
   import video_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] r,
   input  logic [5:0] g,
   input  logic [5:0] b,
   output logic [5:0] luma
);

   logic [13:0] sum;
   logic [5:0]  luma_d;
   logic [5:0]  luma_q;

   always_comb begin
      sum = mul_sa(r, LUMA_WR)
          + mul_sa(g, LUMA_WG)
          + mul_sa(b, LUMA_WB);
      luma_d = 6'(sum >> 8);
   end

   always_ff @(posedge clk) begin
      if (rst) luma_q <= '0;
      else     luma_q <= luma_d;
   end

   assign luma = luma_q;

endmodule

// File: rtl/vga_mono_dither.sv
// Three-stage VGA output: luma, mode select, 6->3 bit reduce with
// optional 4x4 ordered dither. Syncs ride along unmodified.
module vga_mono_dither
   import video_pkg::*;
#(
   parameter bit SYNC_POL       = 1'b0,
   parameter bit DITHER_DEFAULT = 1'b1
) (
   input logic              clk_vga,
   input logic              rst,
   vga_mono_dither_if.slave vid
);

   localparam pix_t PIX_RST = '{
      r: '0, g: '0, b: '0, hs: ~SYNC_POL, vs: ~SYNC_POL
   };

   pix_t       s1_d, s1_q;
   pix_t       s2_d, s2_q;
   logic [5:0] luma1;
   logic [1:0] mode_d, mode_q;
   logic       dith_d, dith_q;
   logic       s2_dith_d, s2_dith_q;
   logic [2:0] r3_d, r3_q;
   logic [2:0] g3_d, g3_q;
   logic [2:0] b3_d, b3_q;
   logic       hs3_d, hs3_q;
   logic       vs3_d, vs3_q;
   logic [1:0] x_ph_d, x_ph_q;
   logic [1:0] y_ph_d, y_ph_q;
   logic       vs_edge1;
   logic       hs_edge3;
   logic       vs_edge3;
   logic [2:0] thr;

   function automatic logic act(input logic s);
      return s == SYNC_POL;
   endfunction

   function automatic logic [2:0] reduce(
      input logic [5:0] v,
      input logic       en,
      input logic [2:0] t
   );
      logic [6:0] s;
      s = {1'b0, v} + {4'b0, t};
      if (!en)      return v[5:3];
      else if (s[6]) return 3'd7;
      else          return s[5:3];
   endfunction

   vga_luma_weight u_luma (
      .clk  (clk_vga),
      .rst  (rst),
      .r    (vid.r_in),
      .g    (vid.g_in),
      .b    (vid.b_in),
      .luma (luma1)
   );

   // Mode/dither latch on the frame edge so a frame never tears.
   always_comb begin
      s1_d     = '{r: vid.r_in, g: vid.g_in, b: vid.b_in,
                   hs: vid.hsync_in, vs: vid.vsync_in};
      vs_edge1 = act(vid.vsync_in) & ~act(s1_q.vs);
      mode_d   = vs_edge1 ? vid.mode : mode_q;
      dith_d   = vs_edge1 ? vid.dither_en : dith_q;
   end

   always_comb begin
      s2_d      = s1_q;
      s2_dith_d = dith_q;
      unique case (mode_q)
         MODE_COLOR: begin
            s2_d.r = s1_q.r;
            s2_d.g = s1_q.g;
            s2_d.b = s1_q.b;
         end
         MODE_GREEN: begin
            s2_d.r = '0;
            s2_d.g = luma1;
            s2_d.b = '0;
         end
         MODE_AMBER: begin
            s2_d.r = luma1;
            s2_d.g = luma1 >> 1;
            s2_d.b = '0;
         end
         MODE_WHITE: begin
            s2_d.r = luma1;
            s2_d.g = luma1;
            s2_d.b = luma1;
         end
      endcase
   end

   // Phases index the pixel entering stage 3; sync edges reset them.
   always_comb begin
      thr      = bayer_thr(y_ph_q, x_ph_q);
      r3_d     = reduce(s2_q.r, s2_dith_q, thr);
      g3_d     = reduce(s2_q.g, s2_dith_q, thr);
      b3_d     = reduce(s2_q.b, s2_dith_q, thr);
      hs3_d    = s2_q.hs;
      vs3_d    = s2_q.vs;
      hs_edge3 = act(s2_q.hs) & ~act(hs3_q);
      vs_edge3 = act(s2_q.vs) & ~act(vs3_q);
      x_ph_d   = hs_edge3 ? 2'd0 : x_ph_q + 2'd1;
      if (vs_edge3)      y_ph_d = 2'd0;
      else if (hs_edge3) y_ph_d = y_ph_q + 2'd1;
      else               y_ph_d = y_ph_q;
   end

   always_ff @(posedge clk_vga) begin
      if (rst) begin
         s1_q      <= PIX_RST;
         s2_q      <= PIX_RST;
         mode_q    <= MODE_COLOR;
         dith_q    <= DITHER_DEFAULT;
         s2_dith_q <= DITHER_DEFAULT;
         r3_q      <= '0;
         g3_q      <= '0;
         b3_q      <= '0;
         hs3_q     <= ~SYNC_POL;
         vs3_q     <= ~SYNC_POL;
         x_ph_q    <= '0;
         y_ph_q    <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         mode_q    <= mode_d;
         dith_q    <= dith_d;
         s2_dith_q <= s2_dith_d;
         r3_q      <= r3_d;
         g3_q      <= g3_d;
         b3_q      <= b3_d;
         hs3_q     <= hs3_d;
         vs3_q     <= vs3_d;
         x_ph_q    <= x_ph_d;
         y_ph_q    <= y_ph_d;
      end
   end

   assign vid.VGA_R     = r3_q;
   assign vid.VGA_G     = g3_q;
   assign vid.VGA_B     = b3_q;
   assign vid.VGA_HSYNC = hs3_q;
   assign vid.VGA_VSYNC = vs3_q;

endmodule

// File: tb/tb_vga_mono_dither.sv
// Directed bench for vga_mono_dither: expected pixels are queued as
// they are driven and compared three clocks later at the pins.
module tb_vga_mono_dither;

   logic clk_vga = 1'b0;
   logic rst;

   vga_mono_dither_if vid ();

   vga_mono_dither #(
      .SYNC_POL       (1'b0),
      .DITHER_DEFAULT (1'b1)
   ) dut (
      .clk_vga (clk_vga),
      .rst     (rst),
      .vid     (vid)
   );

   always #5 clk_vga = ~clk_vga;

   typedef struct {
      logic       chk;
      logic       tile;
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
      logic       hs;
      logic       vs;
      int         id;
   } exp_t;

   exp_t q[$];
   int   n_asrt    = 0;
   int   n_fail    = 0;
   int   tile_ones = 0;
   int   step_id   = 0;

   int   bay [16] = '{0, 8, 2, 10, 12, 4, 14, 6,
                      3, 11, 1, 9, 15, 7, 13, 5};

   task automatic check(input string tag, input int id,
                        input logic [2:0] obs,
                        input logic [2:0] expv);
      n_asrt++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s step %0d: got %0d expected %0d",
                tag, id, obs, expv);
      end
   endtask

   // hs_a/vs_a are "sync active" flags; active-low on the pins.
   task automatic step(input logic [5:0] r, g, b,
                       input logic hs_a, vs_a, chk,
                       input logic [2:0] er, eg, eb,
                       input logic tile);
      exp_t e;
      vid.r_in     = r;
      vid.g_in     = g;
      vid.b_in     = b;
      vid.hsync_in = ~hs_a;
      vid.vsync_in = ~vs_a;
      e.chk  = chk;
      e.tile = tile;
      e.r    = er;
      e.g    = eg;
      e.b    = eb;
      e.hs   = ~hs_a;
      e.vs   = ~vs_a;
      e.id   = step_id;
      step_id++;
      q.push_back(e);
      @(posedge clk_vga);
      #1;
      if (q.size() == 3) begin
         e = q.pop_front();
         if (e.chk) begin
            check("vga_r", e.id, vid.VGA_R, e.r);
            check("vga_g", e.id, vid.VGA_G, e.g);
            check("vga_b", e.id, vid.VGA_B, e.b);
         end
         check("hsync", e.id, {2'b0, vid.VGA_HSYNC}, {2'b0, e.hs});
         check("vsync", e.id, {2'b0, vid.VGA_VSYNC}, {2'b0, e.vs});
         if (e.tile && vid.VGA_R == 3'd1) tile_ones++;
      end
   endtask

   task automatic pix(input logic [5:0] r, g, b,
                      input logic [2:0] er, eg, eb);
      step(r, g, b, 1'b0, 1'b0, 1'b1, er, eg, eb, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk_vga);
      #1;
      check("rst_r", step_id, vid.VGA_R, 3'd0);
      check("rst_g", step_id, vid.VGA_G, 3'd0);
      check("rst_b", step_id, vid.VGA_B, 3'd0);
      check("rst_hs", step_id, {2'b0, vid.VGA_HSYNC}, 3'd1);
      check("rst_vs", step_id, {2'b0, vid.VGA_VSYNC}, 3'd1);
      q.delete();
      rst = 1'b0;
   endtask

   initial begin
      int ev;
      rst           = 1'b1;
      vid.r_in      = '0;
      vid.g_in      = '0;
      vid.b_in      = '0;
      vid.hsync_in  = 1'b1;
      vid.vsync_in  = 1'b1;
      vid.mode      = 2'b00;
      vid.dither_en = 1'b0;
      @(posedge clk_vga);
      #1;
      do_reset();

      // colour, dither off latched at frame start; 0x2D -> 5
      step(6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0);
      pix(6'h2D, 6'd0, 6'd0, 3'd5, 3'd0, 3'd0);
      pix(6'h2D, 6'd0, 6'd0, 3'd5, 3'd0, 3'd0);
      step(6'h2D, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd0, 3'd0, 1'b0);
      pix(6'h2D, 6'd0, 6'd0, 3'd5, 3'd0, 3'd0);
      pix(6'h2D, 6'd0, 6'd0, 3'd5, 3'd0, 3'd0);

      // white mode from the vsync pixel on
      vid.mode = 2'b11;
      pix(6'd63, 6'd0, 6'd0, 3'd7, 3'd0, 3'd0);
      step(6'd63, 6'd63, 6'd63, 1'b0, 1'b1, 1'b1, 3'd7, 3'd7, 3'd7, 1'b0);
      pix(6'd63, 6'd0, 6'd0, 3'd1, 3'd1, 3'd1);
      pix(6'd63, 6'd63, 6'd63, 3'd7, 3'd7, 3'd7);

      // amber
      vid.mode = 2'b10;
      step(6'd63, 6'd63, 6'd63, 1'b0, 1'b1, 1'b1, 3'd7, 3'd3, 3'd0, 1'b0);
      pix(6'd63, 6'd63, 6'd63, 3'd7, 3'd3, 3'd0);

      // dithered 4x4 tile of value 4
      vid.mode      = 2'b00;
      vid.dither_en = 1'b1;
      step(6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0);
      for (int y = 0; y < 4; y++) begin
         if (y > 0)
            step(6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1,
                 3'd0, 3'd0, 3'd0, 1'b0);
         for (int x = 0; x < 4; x++) begin
            ev = (4 + bay[y * 4 + x] / 2) / 8;
            step(6'd4, 6'd4, 6'd4, 1'b0, 1'b0, 1'b1,
                 3'(ev), 3'(ev), 3'(ev), 1'b1);
         end
      end

      // saturation with dither on
      for (int i = 0; i < 4; i++)
         pix(6'd63, 6'd63, 6'd63, 3'd7, 3'd7, 3'd7);
      n_asrt++;
      assert (tile_ones == 8) else begin
         n_fail++;
         $error("FAIL tile_ones: got %0d expected 8", tile_ones);
      end

      // mid-frame mode change deferred to next frame
      step(6'd63, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 3'd7, 3'd0, 3'd0, 1'b0);
      vid.mode      = 2'b01;
      vid.dither_en = 1'b0;
      for (int i = 0; i < 3; i++)
         pix(6'd63, 6'd0, 6'd0, 3'd7, 3'd0, 3'd0);
      step(6'd63, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 3'd0, 1'b0);
      pix(6'd63, 6'd0, 6'd0, 3'd0, 3'd1, 3'd0);
      pix(6'd63, 6'd0, 6'd0, 3'd0, 3'd1, 3'd0);

      // reset mid-line: back to colour without a vsync edge
      do_reset();
      for (int i = 0; i < 4; i++)
         pix(6'd63, 6'd0, 6'd0, 3'd7, 3'd0, 3'd0);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
